// File: rtl/sprite_mem_arbiter_if.sv
// rtl/sprite_mem_arbiter_if.sv - requester A/B and sprite memory signals of the arbiter
// slave: arbiter side; master: requesters plus the memory model.
interface sprite_mem_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   parameter int BE_W   = 2
);
   logic              a_req;
   logic [ADDR_W-1:0] a_addr;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic [BE_W-1:0]   b_be;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic              mem_debugaccess;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   modport slave (
      input  a_req, a_addr,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata, b_be,
      output b_gnt, b_rvalid, b_rdata,
      output mem_address, mem_byteenable, mem_chipselect, mem_write,
      output mem_debugaccess, mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport master (
      output a_req, a_addr,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata, b_be,
      input  b_gnt, b_rvalid, b_rdata,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write,
      input  mem_debugaccess, mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - two-port arbiter for a single-port 128x16 sprite memory
// ARB_ROUND_ROBIN_EN selects alternating priority; default is A priority with a B starvation guard.
module sprite_mem_arbiter #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 16,
   parameter int BE_W       = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   sprite_mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {RD_NONE, RD_A, RD_B} rd_owner_e;

   rd_owner_e         rd_owner_q, rd_owner_d;
   logic              a_rvalid_q, a_rvalid_d;
   logic              b_rvalid_q, b_rvalid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              a_gnt, b_gnt, b_wins;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_b_q, last_b_d;

   assign b_wins = ~bus.a_req | ~last_b_q;

   always_comb begin
      last_b_d = last_b_q;
      if (b_gnt)
         last_b_d = 1'b1;
      else if (a_gnt)
         last_b_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_b_q <= 1'b0;
      else
         last_b_q <= last_b_d;
   end
`else
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic [7:0] starve_cnt_q, starve_cnt_d;
   logic       starve_hit;

   // Once B has waited STARVE_MAX cycles it takes exactly one slot, then A resumes.
   assign starve_hit = (starve_cnt_q == STARVE_LIM);
   assign b_wins     = ~bus.a_req | starve_hit;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (b_gnt || !bus.b_req)
         starve_cnt_d = 8'd0;
      else if (!starve_hit)
         starve_cnt_d = starve_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt_q <= 8'd0;
      else
         starve_cnt_q <= starve_cnt_d;
   end
`endif

   assign b_gnt = ~reset & bus.b_req & b_wins;
   assign a_gnt = ~reset & bus.a_req & ~b_gnt;

   // Idle cycles keep the last issued address on the bus to avoid needless toggling.
   always_comb begin
      addr_d              = addr_q;
      bus.mem_byteenable  = '1;
      if (a_gnt) begin
         addr_d = bus.a_addr;
      end else if (b_gnt) begin
         addr_d = bus.b_addr;
         if (bus.b_we)
            bus.mem_byteenable = bus.b_be;
      end
   end

   assign bus.mem_address     = addr_d;
   assign bus.mem_chipselect  = a_gnt | b_gnt;
   assign bus.mem_write       = b_gnt & bus.b_we;
   assign bus.mem_debugaccess = b_gnt & bus.b_we;
   assign bus.mem_writedata   = bus.b_wdata;
   assign bus.mem_clken       = 1'b1;
   assign bus.a_gnt           = a_gnt;
   assign bus.b_gnt           = b_gnt;

   always_comb begin
      rd_owner_d = RD_NONE;
      if (a_gnt)
         rd_owner_d = RD_A;
      else if (b_gnt && !bus.b_we)
         rd_owner_d = RD_B;
      a_rvalid_d = (rd_owner_d == RD_A);
      b_rvalid_d = (rd_owner_d == RD_B);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_owner_q <= RD_NONE;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         addr_q     <= '0;
      end else begin
         rd_owner_q <= rd_owner_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         addr_q     <= addr_d;
      end
   end

   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.a_rdata  = (rd_owner_q == RD_A) ? bus.mem_readdata : '0;
   assign bus.b_rdata  = (rd_owner_q == RD_B) ? bus.mem_readdata : '0;
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb/tb_sprite_mem_arbiter.sv - table-driven bench with read-data scoreboard for sprite_mem_arbiter
// Honours ARB_ROUND_ROBIN_EN for the contention sequences.
module tb_sprite_mem_arbiter;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;
   localparam int BE_W   = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sprite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

   sprite_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .STARVE_MAX(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [15:0] pat(input int i);
      return 16'(i * 16'h0123) ^ 16'hA5C3;
   endfunction

   // Single-port memory model, one-cycle read latency, byte-enabled writes.
   logic [15:0] mem [128];
   logic [15:0] mem_q;
   assign bus.mem_readdata = mem_q;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
   end

   always @(posedge clk) begin
      if (bus.mem_chipselect && bus.mem_clken) begin
         if (bus.mem_write && bus.mem_debugaccess) begin
            if (bus.mem_byteenable[0]) mem[bus.mem_address][7:0]  <= bus.mem_writedata[7:0];
            if (bus.mem_byteenable[1]) mem[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
         end
         mem_q <= mem[bus.mem_address];
      end
   end

   typedef struct {
      bit          rst;
      bit          a_req;
      logic [6:0]  a_addr;
      bit          b_req;
      bit          b_we;
      logic [6:0]  b_addr;
      logic [15:0] b_wdata;
      logic [1:0]  b_be;
      bit          exp_a;
      bit          exp_b;
   } vec_t;

   typedef struct {
      bit          is_b;
      logic [15:0] data;
   } rd_t;

   vec_t        tbl[$];
   rd_t         sb[$];
   logic [15:0] shadow [128];
   logic [6:0]  last_addr;
   int          checks = 0;
   int          errors = 0;

   function automatic vec_t mk(input bit rst, input bit ar, input logic [6:0] aa,
                               input bit br, input bit bw, input logic [6:0] ba,
                               input logic [15:0] wd, input logic [1:0] be,
                               input bit ea, input bit eb);
      vec_t v;
      v.rst = rst; v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_we = bw;
      v.b_addr = ba; v.b_wdata = wd; v.b_be = be; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic run(input vec_t v);
      rd_t        e;
      bit         pa, pb;
      logic [6:0] ea;
      reset       = v.rst;
      bus.a_req   = v.a_req;
      bus.a_addr  = v.a_addr;
      bus.b_req   = v.b_req;
      bus.b_we    = v.b_we;
      bus.b_addr  = v.b_addr;
      bus.b_wdata = v.b_wdata;
      bus.b_be    = v.b_be;
      @(negedge clk);
      pa = 1'b0;
      pb = 1'b0;
      e  = '{1'b0, 16'h0};
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         pa = !e.is_b;
         pb = e.is_b;
      end
      chk("a_rvalid", bus.a_rvalid, pa);
      chk("b_rvalid", bus.b_rvalid, pb);
      if (pa) chk("a_rdata", bus.a_rdata, e.data);
      if (pb) chk("b_rdata", bus.b_rdata, e.data);
      chk("a_gnt", bus.a_gnt, v.exp_a);
      chk("b_gnt", bus.b_gnt, v.exp_b);
      chk("mem_chipselect", bus.mem_chipselect, v.exp_a | v.exp_b);
      chk("mem_write", bus.mem_write, v.exp_b & v.b_we);
      chk("mem_debugaccess", bus.mem_debugaccess, v.exp_b & v.b_we);
      ea = v.exp_a ? v.a_addr : (v.exp_b ? v.b_addr : last_addr);
      chk("mem_address", bus.mem_address, ea);
      if (v.exp_b && v.b_we) begin
         chk("mem_writedata", bus.mem_writedata, v.b_wdata);
         chk("mem_byteenable", bus.mem_byteenable, v.b_be);
      end else if (v.exp_a || v.exp_b) begin
         chk("mem_byteenable_rd", bus.mem_byteenable, 2'b11);
      end
      if (v.exp_a) sb.push_back('{1'b0, shadow[v.a_addr]});
      if (v.exp_b && !v.b_we) sb.push_back('{1'b1, shadow[v.b_addr]});
      if (v.exp_b && v.b_we) begin
         if (v.b_be[0]) shadow[v.b_addr][7:0]  = v.b_wdata[7:0];
         if (v.b_be[1]) shadow[v.b_addr][15:8] = v.b_wdata[15:8];
      end
      last_addr = v.rst ? 7'h0 : ea;
      @(posedge clk);
      #1;
   endtask

   function automatic bit b_turn(input int i);
`ifdef ARB_ROUND_ROBIN_EN
      return (i % 2) == 0;
`else
      return (i % 9) == 8;
`endif
   endfunction

   initial begin
      for (int i = 0; i < 128; i++) shadow[i] = pat(i);
      last_addr   = 7'h0;
      bus.a_req   = 1'b0;
      bus.a_addr  = 7'h0;
      bus.b_req   = 1'b0;
      bus.b_we    = 1'b0;
      bus.b_addr  = 7'h0;
      bus.b_wdata = 16'h0;
      bus.b_be    = 2'b00;
      reset       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mem_clken", bus.mem_clken, 1'b1);

      // rst, a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_be, exp_a, exp_b
      tbl.push_back(mk(1, 1, 7'h05, 1, 0, 7'h10, 16'h0000, 2'b11, 0, 0));
      tbl.push_back(mk(1, 1, 7'h05, 1, 1, 7'h10, 16'h1111, 2'b11, 0, 0));
      tbl.push_back(mk(0, 1, 7'h05, 0, 0, 7'h00, 16'h0000, 2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 7'h06, 0, 0, 7'h00, 16'h0000, 2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 7'h07, 0, 0, 7'h00, 16'h0000, 2'b00, 1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 16'h0000, 2'b00, 0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 1, 7'h10, 16'hBEEF, 2'b11, 0, 1));
      tbl.push_back(mk(0, 0, 7'h00, 1, 0, 7'h10, 16'h0000, 2'b11, 0, 1));
      tbl.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 16'h0000, 2'b00, 0, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 1, 7'h20, 16'h1234, 2'b11, 0, 1));
      tbl.push_back(mk(0, 0, 7'h00, 1, 1, 7'h20, 16'hAB00, 2'b10, 0, 1));
      tbl.push_back(mk(0, 0, 7'h00, 1, 0, 7'h20, 16'h0000, 2'b11, 0, 1));
      tbl.push_back(mk(0, 1, 7'h21, 1, 0, 7'h22, 16'h0000, 2'b11, 1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 0, 7'h22, 16'h0000, 2'b11, 0, 1));
      tbl.push_back(mk(0, 1, 7'h30, 1, 1, 7'h31, 16'h5555, 2'b01, 1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 1, 1, 7'h31, 16'h5555, 2'b01, 0, 1));
      tbl.push_back(mk(0, 1, 7'h31, 0, 0, 7'h00, 16'h0000, 2'b00, 1, 0));
      tbl.push_back(mk(0, 0, 7'h00, 0, 0, 7'h00, 16'h0000, 2'b00, 0, 0));
      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
      chk("byte_merge", shadow[7'h20], 16'hAB34);

      // Both requesters held from a fresh reset.
      run(mk(1, 0, 7'h00, 0, 0, 7'h00, 16'h0000, 2'b00, 0, 0));
      for (int i = 0; i < 27; i++) begin
         bit eb;
         eb = b_turn(i);
         run(mk(0, 1, 7'(i + 64), 1, 0, 7'h10, 16'h0000, 2'b11, !eb, eb));
      end
      // Dropping b_req clears the wait count; in round-robin this A grant hands priority back to B.
      run(mk(0, 1, 7'h02, 0, 0, 7'h00, 16'h0000, 2'b00, 1, 0));
      for (int i = 0; i < 9; i++) begin
         bit eb;
         eb = b_turn(i);
         run(mk(0, 1, 7'(i + 100), 1, 0, 7'h11, 16'h0000, 2'b11, !eb, eb));
      end

      // Reset arriving while an A read is in flight.
      run(mk(0, 1, 7'h44, 0, 0, 7'h00, 16'h0000, 2'b00, 1, 0));
      run(mk(1, 1, 7'h45, 1, 0, 7'h46, 16'h0000, 2'b11, 0, 0));
      run(mk(0, 0, 7'h00, 0, 0, 7'h00, 16'h0000, 2'b00, 0, 0));
      run(mk(0, 0, 7'h00, 0, 0, 7'h00, 16'h0000, 2'b00, 0, 0));
      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
